// File: rtl/pwm_capture.sv
// PWM capture: synchronizes a PWM bitstream, counts high cycles over fixed
// windows of 2^PERIOD_LOG2 clocks and offers one PCM sample per window.
module pwm_capture #(
    parameter int unsigned PERIOD_LOG2 = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pwm_in,
    input  logic                   en,
    output logic [PERIOD_LOG2-1:0] pcm_out,
    output logic                   pcm_out_vld,
    input  logic                   pcm_out_rdy,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam int unsigned W = PERIOD_LOG2;
    localparam logic [W-1:0] WIN_LAST = '1;
    localparam logic [W-1:0] PCM_MAX  = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [W-1:0]           win_cnt;
    logic [W:0]             hi_cnt;
    logic [W:0]             hi_sum;
    logic [W-1:0]           result;
    logic                   win_end;
    logic                   slot_free;
    logic                   load;
    logic                   drop;

    // Input synchronizer; only the last stage is used downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Window bookkeeping and saturated result of the closing window.
    always_comb begin
        win_end   = en & (win_cnt == WIN_LAST);
        hi_sum    = hi_cnt + (W+1)'(s);
        result    = hi_sum[W] ? PCM_MAX : hi_sum[W-1:0];
        slot_free = ~pcm_out_vld | pcm_out_rdy;
        load      = win_end & slot_free;
        drop      = win_end & ~slot_free;
    end

    // Counters restart whenever capture is disabled, discarding the partial window.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            win_cnt <= '0;
            hi_cnt  <= '0;
        end else if (win_end) begin
            win_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            win_cnt <= win_cnt + W'(1);
            hi_cnt  <= hi_sum;
        end
    end

    // Single-entry output slot; a load on the draining edge keeps vld high.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcm_out     <= '0;
            pcm_out_vld <= 1'b0;
        end else if (load) begin
            pcm_out     <= result;
            pcm_out_vld <= 1'b1;
        end else if (pcm_out_vld && pcm_out_rdy) begin
            pcm_out_vld <= 1'b0;
        end
    end

    // Sticky overrun; a drop on the clearing cycle takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: constant levels, encoder loopback,
// backpressure/overrun, simultaneous drain+load and enable gaps.
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic       pwm_drv;
    logic       en;
    logic [7:0] pcm_out;
    logic       pcm_out_vld;
    logic       pcm_out_rdy;
    logic       overrun;
    logic       overrun_clr;
    logic       pwm_in;

    logic [7:0] enc_cnt  = 8'd0;
    logic [7:0] enc_duty = 8'd0;
    logic       enc_on   = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    int n;

    always #5 clk = ~clk;

    // Reference PWM encoder: period 256, high while counter < duty.
    always @(posedge clk) enc_cnt <= enc_cnt + 8'd1;
    assign pwm_in = enc_on ? (enc_cnt < enc_duty) : pwm_drv;

    pwm_capture #(.PERIOD_LOG2(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .en          (en),
        .pcm_out     (pcm_out),
        .pcm_out_vld (pcm_out_vld),
        .pcm_out_rdy (pcm_out_rdy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Counts edges until pcm_out_vld is seen; an expired budget is a failure.
    task automatic wait_vld(input int budget, output int cnt);
        cnt = 0;
        while (cnt < budget) begin
            step();
            cnt++;
            if (pcm_out_vld) break;
        end
        if (!pcm_out_vld) check("vld_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        steps(3);
        check({tag, "_rst_pcm"}, 32'(pcm_out), 32'h00);
        check({tag, "_rst_vld"}, 32'(pcm_out_vld), 32'd0);
        check({tag, "_rst_ovr"}, 32'(overrun), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        pwm_drv     = 1'b0;
        en          = 1'b1;
        pcm_out_rdy = 1'b1;
        overrun_clr = 1'b0;
        #1;

        // All-high: first window loses two synchronizer zeros, later ones saturate.
        pwm_drv = 1'b1;
        do_reset("hi");
        wait_vld(300, n);
        check("hi_w1_lat", 32'(n), 32'd256);
        check("hi_w1_val", 32'(pcm_out), 32'hFE);
        step();
        check("hi_w1_drain", 32'(pcm_out_vld), 32'd0);
        wait_vld(300, n);
        check("hi_w2_lat", 32'(n), 32'd255);
        check("hi_w2_val", 32'(pcm_out), 32'hFF);
        step();
        wait_vld(300, n);
        check("hi_w3_val", 32'(pcm_out), 32'hFF);
        check("hi_ovr", 32'(overrun), 32'd0);

        // All-low input.
        pwm_drv = 1'b0;
        do_reset("lo");
        wait_vld(300, n);
        check("lo_w1_lat", 32'(n), 32'd256);
        check("lo_w1_val", 32'(pcm_out), 32'h00);
        step();
        wait_vld(300, n);
        check("lo_w2_val", 32'(pcm_out), 32'h00);

        // Encoder loopback 0x5A, then 0xC3 with one mixed window.
        enc_on   = 1'b1;
        enc_duty = 8'h5A;
        do_reset("lb");
        wait_vld(300, n);
        check("lb_w1_lat", 32'(n), 32'd256);
        step();
        wait_vld(300, n);
        check("lb_w2_val", 32'(pcm_out), 32'h5A);
        step();
        wait_vld(300, n);
        check("lb_w3_val", 32'(pcm_out), 32'h5A);
        enc_duty = 8'hC3;
        step();
        wait_vld(300, n);
        check("lb_mix_rng", 32'(pcm_out >= 8'h5A && pcm_out <= 8'hC3), 32'd1);
        step();
        wait_vld(300, n);
        check("lb_c3_val", 32'(pcm_out), 32'hC3);
        step();
        wait_vld(300, n);
        check("lb_c3_val2", 32'(pcm_out), 32'hC3);
        enc_on = 1'b0;

        // Backpressure across three window ends.
        pwm_drv     = 1'b1;
        pcm_out_rdy = 1'b0;
        do_reset("bp");
        wait_vld(300, n);
        check("bp_w1_val", 32'(pcm_out), 32'hFE);
        check("bp_w1_ovr", 32'(overrun), 32'd0);
        steps(256);
        check("bp_w2_hold", 32'(pcm_out), 32'hFE);
        check("bp_w2_vld", 32'(pcm_out_vld), 32'd1);
        check("bp_w2_ovr", 32'(overrun), 32'd1);
        steps(256);
        check("bp_w3_hold", 32'(pcm_out), 32'hFE);
        check("bp_w3_ovr", 32'(overrun), 32'd1);
        pcm_out_rdy = 1'b1;
        step();
        check("bp_drain_vld", 32'(pcm_out_vld), 32'd0);
        check("bp_ovr_sticky", 32'(overrun), 32'd1);
        wait_vld(300, n);
        check("bp_next_lat", 32'(n), 32'd255);
        check("bp_next_val", 32'(pcm_out), 32'hFF);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("bp_ovr_clr", 32'(overrun), 32'd0);

        // Drain and load on the same edge.
        pcm_out_rdy = 1'b0;
        do_reset("dl");
        wait_vld(300, n);
        check("dl_w1_val", 32'(pcm_out), 32'hFE);
        steps(255);
        check("dl_pre_vld", 32'(pcm_out_vld), 32'd1);
        pcm_out_rdy = 1'b1;
        step();
        pcm_out_rdy = 1'b0;
        check("dl_vld", 32'(pcm_out_vld), 32'd1);
        check("dl_val", 32'(pcm_out), 32'hFF);
        check("dl_ovr", 32'(overrun), 32'd0);

        // Reset with a pending sample discards it.
        do_reset("mid");

        // Enable gap at window cycle 100; pending sample drains during the gap.
        wait_vld(300, n);
        check("eg_w1_val", 32'(pcm_out), 32'hFE);
        steps(100);
        en          = 1'b0;
        pcm_out_rdy = 1'b1;
        step();
        check("eg_drain", 32'(pcm_out_vld), 32'd0);
        steps(9);
        check("eg_no_smp", 32'(pcm_out_vld), 32'd0);
        en = 1'b1;
        wait_vld(300, n);
        check("eg_lat", 32'(n), 32'd256);
        check("eg_val", 32'(pcm_out), 32'hFF);
        check("eg_ovr", 32'(overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart to the PWM audio encoder. Samples a single-bit PWM audio stream, measures the high-time over fixed windows of 2^PERIOD_LOG2 clocks, and emits one PCM sample per window on a valid/ready channel. It is the same channel style the bytebeat generators use for their output. It serves as the loopback decoder for on-chip self-test and bench checking of the audio path, and as an input path for external PWM sources on a uio pin.

## Interface

Parameters:
- PERIOD_LOG2, 8, window length is 2^PERIOD_LOG2 clocks; also the PCM sample width W.
- SYNC_STAGES, 2, depth of the input synchronizer flop chain; minimum 2.

Ports:
- clk  input  1  single clock; all state is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pwm_in  input  1  asynchronous PWM bitstream.
- en  input  1  capture enable; while low, windows do not advance.
- pcm_out  output  W  decoded sample.
- pcm_out_vld  output  1  pcm_out holds an undelivered sample.
- pcm_out_rdy  input  1  downstream accepts the sample.
- overrun  output  1  sticky; a window result was dropped.
- overrun_clr  input  1  clears overrun.

## Operation

- Synchronizer: pwm_in passes through SYNC_STAGES flops, all reset to 0. The last stage, s, is the only internal use of pwm_in.
- Window counter win_cnt (W bits) and high accumulator hi_cnt (W+1 bits):
  - Both advance only when en=1.
  - win_cnt increments by 1 and wraps from 2^W-1 to 0.
  - hi_cnt adds s on every enabled cycle.
- End of window, i.e. an enabled cycle with win_cnt == 2^W-1:
  - The result is hi_cnt + s, saturated to 2^W-1. Only an all-high window saturates; the encoder's maximum is 2^W-1 highs.
  - hi_cnt clears to 0 on the same edge.
- Output slot (single entry):
  - At end of window, if pcm_out_vld=0 or (pcm_out_vld & pcm_out_rdy), the result loads into pcm_out and pcm_out_vld=1.
  - Otherwise the result is dropped, pcm_out keeps the old value, and overrun sets.
  - Handshake: a transfer occurs on any cycle with pcm_out_vld & pcm_out_rdy. pcm_out_vld clears after a transfer unless a new result loads on the same edge, in which case it stays 1 with the new value.
  - pcm_out is stable while pcm_out_vld=1 and pcm_out_rdy=0.
  - pcm_out_rdy is ignored while pcm_out_vld=0.
- en low:
  - win_cnt and hi_cnt clear to 0 and the partial window is discarded.
  - The synchronizer keeps running.
  - The output slot and its handshake are unaffected, so a pending sample can still drain.
- overrun:
  - Set by a dropped result; cleared by overrun_clr.
  - If a drop and overrun_clr coincide, set wins and overrun=1.
- Reset values:
  - pcm_out = 0, pcm_out_vld = 0, overrun = 0.
  - win_cnt = 0, hi_cnt = 0, synchronizer = 0.
  - Reset mid-window discards the window and any pending sample.

## Timing

- pwm_in to s: SYNC_STAGES clocks.
- Window: exactly 2^W consecutive enabled cycles. The first window starts on the first enabled cycle after reset or after en rises.
- pcm_out_vld rises on the edge ending a window's last cycle. One sample is produced per 2^W enabled cycles; sustained throughput needs only one accept per window.
- Accuracy:
  - For a PWM source with period 2^W and constant duty D, every window reads exactly D, since any 2^W-cycle span covers one full period.
  - Exception: the first window after reset reads up to SYNC_STAGES low, because the synchronizer resets to zeros.
- No combinational path from pcm_out_rdy to any output; all outputs are registered.

## Test plan

- All-high input: pwm_in=1, en=1, rdy=1 from reset.
  - First sample is 0xFF-SYNC_STAGES+... saturated: 256 highs minus 2 reset zeros gives 0xFE.
  - Later samples are 0xFF, one vld pulse every 256 clocks.
- All-low input: pwm_in=0 gives 0x00 each window.
- Loopback from the PWM encoder with sample 0x5A:
  - Windows 2 onward give exactly 0x5A.
  - Change the encoder sample to 0xC3 mid-run: one mixed window, then 0xC3.
- Backpressure: rdy=0 across 3 window ends.
  - pcm_out holds the first result and overrun=1 after window 2.
  - Raise rdy: one transfer, then vld stays 0 until the next window end.
  - Pulse overrun_clr: overrun=0.
- Simultaneous drain and load: vld=1 and rdy asserted exactly on the end-of-window cycle.
  - New value loads, vld stays 1, overrun stays 0.
- Enable gap: drop en at window cycle 100 for 10 clocks, then re-raise.
  - No sample from the aborted window.
  - Next vld arrives exactly 256 clocks after en re-rises, with the full-window count.
  - A sample pending before the gap still drains during the gap.
